// File: rtl/ring_mem_requester_pkg.sv
// Shared ring-protocol constants and types for the memory requester slice.
// Slot-type codes and Address-slot bit positions match the ring defines used by the controller.
package ring_mem_requester_pkg;

   localparam logic [3:0] SLOT_NULL      = 4'd0;
   localparam logic [3:0] SLOT_TOKEN     = 4'd1;
   localparam logic [3:0] SLOT_ADDRESS   = 4'd2;
   localparam logic [3:0] SLOT_WRITEDATA = 4'd3;

   localparam int ADDR_READ_BIT = 28;
   localparam int ADDR_EXCL_BIT = 29;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_TOKEN = 3'd1,
      S_SEND_ADDR  = 3'd2,
      S_SEND_WDATA = 3'd3,
      S_RELEASE    = 3'd4,
      S_WAIT_RD    = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      SEL_FWD   = 3'd0,
      SEL_NULL  = 3'd1,
      SEL_ADDR  = 3'd2,
      SEL_WDATA = 3'd3,
      SEL_TOKEN = 3'd4
   } slot_sel_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  stype;
      logic [3:0]  src;
   } slot_t;

endpackage

// File: rtl/ring_mem_requester_slot_mux.sv
// Chooses what the requester drives onto the ring output registers this cycle.
module ring_slot_mux
   import ring_mem_requester_pkg::*;
(
   input  slot_sel_t   sel_i,
   input  slot_t       fwd_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  core_i,
   output slot_t       slot_o
);

   always_comb begin
      slot_o = fwd_i;
      case (sel_i)
         SEL_NULL:  slot_o = '{data: 32'd0,   stype: SLOT_NULL,      src: 4'd0};
         SEL_ADDR:  slot_o = '{data: addr_i,  stype: SLOT_ADDRESS,   src: core_i};
         SEL_WDATA: slot_o = '{data: wdata_i, stype: SLOT_WRITEDATA, src: core_i};
         SEL_TOKEN: slot_o = '{data: 32'd0,   stype: SLOT_TOKEN,     src: 4'd0};
         default:   slot_o = fwd_i;
      endcase
   end

endmodule

// File: rtl/ring_mem_requester.sv
// Core-side ring initiator: captures the token, issues one cache-line read or
// writeback, re-emits the token and collects returned read words.
module ring_mem_requester
   import ring_mem_requester_pkg::*;
#(
   parameter int LINE_WORDS = 8,
   parameter int LINE_BITS  = 28,
   parameter int RD_TIMEOUT = 4096
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [3:0]           whichCore,
   input  logic [31:0]          RingIn,
   input  logic [3:0]           SlotTypeIn,
   input  logic [3:0]           SourceIn,
   input  logic [31:0]          RDreturn,
   input  logic [3:0]           RDdest,
   output logic [31:0]          RingOut,
   output logic [3:0]           SlotTypeOut,
   output logic [3:0]           SourceOut,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic                 req_excl,
   input  logic [LINE_BITS-1:0] req_line,
   input  logic [31:0]          wr_data,
   output logic                 wr_pop,
   output logic [31:0]          rd_data,
   output logic                 rd_valid,
   output logic                 rd_last,
   output logic                 rd_timeout
);

   localparam int CNT_W = $clog2(LINE_WORDS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

   state_t               state_q;
   logic                 write_q, excl_q;
   logic [LINE_BITS-1:0] line_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [31:0]          wd_q;
   slot_t                slot_q, slot_d;
   slot_sel_t            sel;
   logic [31:0]          addr_w;
   logic                 rd_hit, holding;
   logic [31:0]          rd_data_q;
   logic                 rd_valid_q, rd_last_q, rd_timeout_q;

   assign rd_hit  = (RDdest == whichCore) && (RDdest != 4'd0);
   assign holding = (state_q == S_SEND_ADDR) || (state_q == S_SEND_WDATA) ||
                    (state_q == S_RELEASE);

   always_comb begin
      addr_w                  = '0;
      addr_w[LINE_BITS-1:0]   = line_q;
      addr_w[ADDR_READ_BIT]   = ~write_q;
      addr_w[ADDR_EXCL_BIT]   = excl_q;
   end

   // Token is swallowed by emitting Null in the cycle it arrives.
   always_comb begin
      sel = SEL_FWD;
      case (state_q)
         S_WAIT_TOKEN: sel = (SlotTypeIn == SLOT_TOKEN) ? SEL_NULL : SEL_FWD;
         S_SEND_ADDR:  sel = SEL_ADDR;
         S_SEND_WDATA: sel = SEL_WDATA;
         S_RELEASE:    sel = SEL_TOKEN;
         default:      sel = SEL_FWD;
      endcase
   end

   ring_slot_mux u_mux (
      .sel_i   (sel),
      .fwd_i   ('{data: RingIn, stype: SlotTypeIn, src: SourceIn}),
      .addr_i  (addr_w),
      .wdata_i (wr_data),
      .core_i  (whichCore),
      .slot_o  (slot_d)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         slot_q       <= '{data: 32'd0, stype: SLOT_NULL, src: 4'd0};
         write_q      <= 1'b0;
         excl_q       <= 1'b0;
         line_q       <= '0;
         cnt_q        <= '0;
         wd_q         <= '0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         rd_timeout_q <= 1'b0;
      end else begin
         slot_q       <= slot_d;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         rd_timeout_q <= 1'b0;
         case (state_q)
            S_IDLE: if (req_valid) begin
               write_q <= req_write;
               excl_q  <= req_excl;
               line_q  <= req_line;
               state_q <= S_WAIT_TOKEN;
            end
            S_WAIT_TOKEN: if (SlotTypeIn == SLOT_TOKEN) state_q <= S_SEND_ADDR;
            S_SEND_ADDR:  state_q <= write_q ? S_SEND_WDATA : S_RELEASE;
            S_SEND_WDATA: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) state_q <= S_RELEASE;
            end
            S_RELEASE: begin
               wd_q    <= '0;
               state_q <= write_q ? S_IDLE : S_WAIT_RD;
            end
            S_WAIT_RD: begin
               if (rd_hit) begin
                  rd_data_q  <= RDreturn;
                  rd_valid_q <= 1'b1;
                  cnt_q      <= cnt_q + 1'b1;
                  wd_q       <= '0;
                  if (cnt_q == CNT_LAST) begin
                     rd_last_q <= 1'b1;
                     state_q   <= S_IDLE;
                  end
               end else if (RD_TIMEOUT != 0) begin
                  // Re-arms after each pulse; the request is never re-issued.
                  if (wd_q == 32'(RD_TIMEOUT - 1)) begin
                     rd_timeout_q <= 1'b1;
                     wd_q         <= '0;
                  end else begin
                     wd_q <= wd_q + 32'd1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign RingOut     = slot_q.data;
   assign SlotTypeOut = slot_q.stype;
   assign SourceOut   = slot_q.src;
   assign req_ready   = (state_q == S_IDLE);
   assign wr_pop      = (state_q == S_SEND_WDATA);
   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign rd_last     = rd_last_q;
   assign rd_timeout  = rd_timeout_q;

   // Only the token holder may insert, and returns must only target an outstanding read.
   a_ring_quiet: assert property (@(posedge clock) disable iff (reset)
      holding |-> (SlotTypeIn == SLOT_NULL));
   a_rd_unexpected: assert property (@(posedge clock) disable iff (reset)
      !(rd_hit && (state_q != S_WAIT_RD)));

endmodule

// File: tb/tb_ring_mem_requester.sv
// Directed bench for ring_mem_requester: pass-through, read, write, interleaved
// returns, watchdog and mid-write reset.
module tb_ring_mem_requester;
   import ring_mem_requester_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  whichCore = 4'd2;
   logic [31:0] RingIn;
   logic [3:0]  SlotTypeIn, SourceIn;
   logic [31:0] RDreturn;
   logic [3:0]  RDdest;
   logic [31:0] RingOut;
   logic [3:0]  SlotTypeOut, SourceOut;
   logic        req_valid, req_ready, req_write, req_excl;
   logic [27:0] req_line;
   logic [31:0] wr_data;
   logic        wr_pop;
   logic [31:0] rd_data;
   logic        rd_valid, rd_last, rd_timeout;

   int checks = 0;
   int failures = 0;

   // Write-data FIFO model: first-word-fall-through values 1..N, advanced by wr_pop.
   int  widx;
   logic wr_clr;
   assign wr_data = 32'(widx + 1);
   always @(posedge clock) begin
      if (wr_clr) widx <= 0;
      else if (wr_pop) widx <= widx + 1;
   end

   always #5 clock = ~clock;

   ring_mem_requester #(.LINE_WORDS(8), .LINE_BITS(28), .RD_TIMEOUT(16)) dut (
      .clock(clock), .reset(reset), .whichCore(whichCore),
      .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
      .RDreturn(RDreturn), .RDdest(RDdest),
      .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_excl(req_excl), .req_line(req_line),
      .wr_data(wr_data), .wr_pop(wr_pop),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_timeout(rd_timeout)
   );

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic ring_null();
      RingIn = 32'd0; SlotTypeIn = SLOT_NULL; SourceIn = 4'd0;
   endtask

   // Issue a request and deliver the token; returns right after the capture edge.
   task automatic start_req(input logic wr, input logic ex, input logic [27:0] line);
      req_valid = 1'b1; req_write = wr; req_excl = ex; req_line = line;
      tick();
      req_valid = 1'b0;
      tick();
      RingIn = 32'd0; SlotTypeIn = SLOT_TOKEN; SourceIn = 4'd0;
      tick();
      ring_null();
   endtask

   task automatic test_reset();
      reset = 1'b1; wr_clr = 1'b1;
      ring_null(); RDreturn = 32'd0; RDdest = 4'd0;
      req_valid = 1'b0; req_write = 1'b0; req_excl = 1'b0; req_line = '0;
      tick(); tick();
      reset = 1'b0; wr_clr = 1'b0;
      checks++; if (RingOut !== 32'd0) begin failures++; $display("FAIL reset_ringout got=%h exp=0", RingOut); end
      checks++; if (SlotTypeOut !== SLOT_NULL) begin failures++; $display("FAIL reset_slottype got=%h exp=%h", SlotTypeOut, SLOT_NULL); end
      checks++; if (SourceOut !== 4'd0) begin failures++; $display("FAIL reset_source got=%h exp=0", SourceOut); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      checks++; if ({rd_valid, rd_last, rd_timeout, wr_pop} !== 4'b0000) begin failures++;
         $display("FAIL reset_flags got=%b exp=0000", {rd_valid, rd_last, rd_timeout, wr_pop}); end
   endtask

   task automatic test_passthrough();
      RingIn = 32'hCAFE_0001; SlotTypeIn = SLOT_TOKEN; SourceIn = 4'd5;
      tick();
      RingIn = 32'h1234_5678; SlotTypeIn = SLOT_WRITEDATA; SourceIn = 4'd7;
      checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {SLOT_TOKEN, 4'd5, 32'hCAFE_0001}) begin failures++;
         $display("FAIL pass_token got=%h/%h/%h exp=%h/5/cafe0001", SlotTypeOut, SourceOut, RingOut, SLOT_TOKEN); end
      tick();
      ring_null();
      checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {SLOT_WRITEDATA, 4'd7, 32'h1234_5678}) begin failures++;
         $display("FAIL pass_wdata got=%h/%h/%h exp=%h/7/12345678", SlotTypeOut, SourceOut, RingOut, SLOT_WRITEDATA); end
      tick();
   endtask

   task automatic test_read();
      start_req(1'b0, 1'b0, 28'h000_0123);
      checks++; if (SlotTypeOut !== SLOT_NULL || RingOut !== 32'd0) begin failures++;
         $display("FAIL rd_capture got=%h/%h exp=%h/0", SlotTypeOut, RingOut, SLOT_NULL); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rd_busy got=%b exp=0", req_ready); end
      tick();
      checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {SLOT_ADDRESS, 4'd2, 32'h1000_0123}) begin failures++;
         $display("FAIL rd_addr got=%h/%h/%h exp=%h/2/10000123", SlotTypeOut, SourceOut, RingOut, SLOT_ADDRESS); end
      tick();
      checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {SLOT_TOKEN, 4'd0, 32'd0}) begin failures++;
         $display("FAIL rd_release got=%h/%h/%h exp=%h/0/0", SlotTypeOut, SourceOut, RingOut, SLOT_TOKEN); end
      for (int i = 0; i < 8; i++) begin
         RDdest = 4'd2; RDreturn = 32'hA000_0000 + 32'(i);
         tick();
         checks++; if ({rd_valid, rd_last, rd_data} !== {1'b1, (i == 7), 32'hA000_0000 + 32'(i)}) begin failures++;
            $display("FAIL rd_word%0d got=v%b l%b %h exp=v1 l%b %h", i, rd_valid, rd_last, rd_data, (i == 7), 32'hA000_0000 + 32'(i)); end
      end
      RDdest = 4'd0; RDreturn = 32'd0;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rd_done_ready got=%b exp=1", req_ready); end
      tick();
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_drop got=%b exp=0", rd_valid); end
   endtask

   task automatic test_write();
      wr_clr = 1'b1; tick(); wr_clr = 1'b0;
      start_req(1'b1, 1'b1, 28'h000_0040);
      tick();
      checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {SLOT_ADDRESS, 4'd2, 32'h2000_0040}) begin failures++;
         $display("FAIL wr_addr got=%h/%h/%h exp=%h/2/20000040", SlotTypeOut, SourceOut, RingOut, SLOT_ADDRESS); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (wr_pop !== 1'b1) begin failures++; $display("FAIL wr_pop%0d got=%b exp=1", i, wr_pop); end
         tick();
         checks++; if (SlotTypeOut !== SLOT_WRITEDATA || RingOut !== 32'(i + 1)) begin failures++;
            $display("FAIL wr_word%0d got=%h/%h exp=%h/%h", i, SlotTypeOut, RingOut, SLOT_WRITEDATA, i + 1); end
      end
      checks++; if (wr_pop !== 1'b0) begin failures++; $display("FAIL wr_pop_end got=%b exp=0", wr_pop); end
      tick();
      checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {SLOT_TOKEN, 4'd0, 32'd0}) begin failures++;
         $display("FAIL wr_release got=%h/%h/%h exp=%h/0/0", SlotTypeOut, SourceOut, RingOut, SLOT_TOKEN); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL wr_no_wait_rd got=%b exp=1", req_ready); end
      checks++; if (widx !== 8) begin failures++; $display("FAIL wr_pop_count got=%0d exp=8", widx); end
   endtask

   task automatic test_interleave();
      start_req(1'b0, 1'b1, 28'hABC_DEF0);
      tick();
      checks++; if (RingOut !== 32'h3ABC_DEF0) begin failures++; $display("FAIL il_addr got=%h exp=3abcdef0", RingOut); end
      tick();
      for (int i = 0; i < 16; i++) begin
         RingIn = 32'hD000_0000 + 32'(i); SlotTypeIn = SLOT_WRITEDATA; SourceIn = 4'd3;
         RDdest = (i % 2 == 0) ? 4'd3 : 4'd2; RDreturn = 32'h0000_0B00 + 32'(i);
         tick();
         checks++; if (RingOut !== 32'hD000_0000 + 32'(i) || SourceOut !== 4'd3) begin failures++;
            $display("FAIL il_fwd%0d got=%h/%h exp=%h/3", i, RingOut, SourceOut, 32'hD000_0000 + 32'(i)); end
         checks++; if (rd_valid !== (i % 2 == 1) || rd_last !== (i == 15)) begin failures++;
            $display("FAIL il_valid%0d got=v%b l%b exp=v%b l%b", i, rd_valid, rd_last, (i % 2 == 1), (i == 15)); end
         if (i % 2 == 1) begin
            checks++; if (rd_data !== 32'h0000_0B00 + 32'(i)) begin failures++;
               $display("FAIL il_data%0d got=%h exp=%h", i, rd_data, 32'h0000_0B00 + 32'(i)); end
         end
      end
      ring_null(); RDdest = 4'd0;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL il_done_ready got=%b exp=1", req_ready); end
      tick();
   endtask

   task automatic test_timeout();
      start_req(1'b0, 1'b0, 28'h000_0005);
      tick(); tick();
      checks++; if (SlotTypeOut !== SLOT_TOKEN) begin failures++; $display("FAIL to_release got=%h exp=%h", SlotTypeOut, SLOT_TOKEN); end
      for (int c = 1; c <= 17; c++) begin
         tick();
         checks++; if (rd_timeout !== (c == 16)) begin failures++;
            $display("FAIL to_pulse_c%0d got=%b exp=%b", c, rd_timeout, (c == 16)); end
      end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL to_still_waiting got=%b exp=0", req_ready); end
      for (int i = 0; i < 8; i++) begin
         RDdest = 4'd2; RDreturn = 32'h5500_0000 + 32'(i);
         tick();
         checks++; if ({rd_valid, rd_last, rd_data} !== {1'b1, (i == 7), 32'h5500_0000 + 32'(i)}) begin failures++;
            $display("FAIL to_late%0d got=v%b l%b %h exp=v1 l%b %h", i, rd_valid, rd_last, rd_data, (i == 7), 32'h5500_0000 + 32'(i)); end
      end
      RDdest = 4'd0;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL to_done_ready got=%b exp=1", req_ready); end
      tick();
   endtask

   task automatic test_reset_mid();
      wr_clr = 1'b1; tick(); wr_clr = 1'b0;
      start_req(1'b1, 1'b0, 28'h000_0077);
      tick();
      tick(); tick(); tick();
      checks++; if (RingOut !== 32'd3 || wr_pop !== 1'b1) begin failures++;
         $display("FAIL rm_pre got=%h pop=%b exp=3 pop=1", RingOut, wr_pop); end
      reset = 1'b1;
      tick();
      checks++; if ({SlotTypeOut, SourceOut, RingOut} !== {SLOT_NULL, 4'd0, 32'd0}) begin failures++;
         $display("FAIL rm_out got=%h/%h/%h exp=%h/0/0", SlotTypeOut, SourceOut, RingOut, SLOT_NULL); end
      checks++; if (req_ready !== 1'b1 || wr_pop !== 1'b0) begin failures++;
         $display("FAIL rm_ready got=r%b p%b exp=r1 p0", req_ready, wr_pop); end
      reset = 1'b0;
      RingIn = 32'h0000_00AA; SlotTypeIn = SLOT_TOKEN; SourceIn = 4'd1;
      tick();
      ring_null();
      checks++; if ({SlotTypeOut, RingOut} !== {SLOT_TOKEN, 32'h0000_00AA}) begin failures++;
         $display("FAIL rm_after got=%h/%h exp=%h/aa", SlotTypeOut, RingOut, SLOT_TOKEN); end
      tick();
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_read();
      test_write();
      test_interleave();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
